// File: rtl/jy61p_frame_parser.sv
// rtl/jy61p_frame_parser.sv - JY61P IMU 11-byte frame reassembler, checksum validator and register latch
//
// Purpose:
//   Turns the uart_recv byte stream (uart_done level + uart_data) into JY61P frames
//   (0x55, type, 8 data bytes = 4 x int16 little-endian, checksum), checks the 8-bit
//   running sum and latches the accel (0x51), gyro (0x52) and angle (0x53) groups.
//   Each group update is flagged with a one-cycle *_vld pulse; a bad checksum gives
//   a one-cycle csum_err pulse.
//
// Optional feature macro: JY61P_ERR_CNT_EN (adds err_clr / err_cnt checksum error counter)
//
// Ports:
//   clk                 in   1   system clock
//   rstn                in   1   asynchronous active-low reset
//   uart_done           in   1   byte-valid level, may stay high for many cycles
//   uart_data           in   8   received byte, valid while uart_done=1
//   acc_x/acc_y/acc_z   out  16  words 0..2 of a type 0x51 frame
//   temp                out  16  word 3 of a type 0x51 frame
//   gyro_x/gyro_y/gyro_z out 16  words 0..2 of a type 0x52 frame
//   roll/pitch/yaw      out  16  words 0..2 of a type 0x53 frame
//   acc_vld/gyro_vld/angle_vld out 1  one-cycle pulse on group update
//   csum_err            out  1   one-cycle pulse on checksum mismatch
//   err_clr             in   1   (JY61P_ERR_CNT_EN) synchronous clear of err_cnt
//   err_cnt             out  16  (JY61P_ERR_CNT_EN) saturating checksum error count

module jy61p_frame_parser #(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        uart_done,
  input  logic [7:0]  uart_data,
  output logic [15:0] acc_x,
  output logic [15:0] acc_y,
  output logic [15:0] acc_z,
  output logic [15:0] temp,
  output logic [15:0] gyro_x,
  output logic [15:0] gyro_y,
  output logic [15:0] gyro_z,
  output logic [15:0] roll,
  output logic [15:0] pitch,
  output logic [15:0] yaw,
  output logic        acc_vld,
  output logic        gyro_vld,
  output logic        angle_vld,
`ifdef JY61P_ERR_CNT_EN
  input  logic        err_clr,
  output logic [15:0] err_cnt,
`endif
  output logic        csum_err
);

  localparam int          CW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [7:0]  HEAD     = 8'h55;
  localparam logic [7:0]  T_ACC    = 8'h51;
  localparam logic [7:0]  T_GYRO   = 8'h52;
  localparam logic [7:0]  T_ANGLE  = 8'h53;

  typedef enum logic [1:0] {
    S_HEAD,
    S_TYPE,
    S_DATA,
    S_SUM
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_uart_done_d;
  logic          w_stb;
  logic          w_timeout;
  logic          w_commit;
  logic          w_bad;
  logic [7:0]    r_sum;
  logic [7:0]    r_type;
  logic [2:0]    r_idx;
  logic [63:0]   r_buf;     // data byte k lives in bits [8k+7:8k]
  logic [CW-1:0] r_tmo_cnt;

  // uart_done is a level; only its rising edge represents a new byte
  assign w_stb     = uart_done & ~r_uart_done_d;
  assign w_timeout = (r_tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_HEAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    w_bad       = 1'b0;
    case (r_state)
      S_HEAD: begin
        if (w_stb && (uart_data == HEAD)) begin
          w_state_nxt = S_TYPE;
        end
      end
      S_TYPE: begin
        if (w_stb) begin
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (w_stb && (r_idx == 3'd7)) begin
          w_state_nxt = S_SUM;
        end
      end
      S_SUM: begin
        if (w_stb) begin
          w_state_nxt = S_HEAD;
          if (uart_data == r_sum) begin
            w_commit = 1'b1;
          end else begin
            w_bad = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_HEAD;
    endcase
    // a byte arriving in the expiry cycle still counts, so timeout only acts without stb
    if (!w_stb && w_timeout) begin
      w_state_nxt = S_HEAD;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_uart_done_d <= 1'b0;
      r_sum         <= 8'h00;
      r_type        <= 8'h00;
      r_idx         <= 3'd0;
      r_buf         <= 64'h0;
      r_tmo_cnt     <= '0;
    end else begin
      r_uart_done_d <= uart_done;

      if (w_stb || (r_state == S_HEAD) || w_timeout) begin
        r_tmo_cnt <= '0;
      end else begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end

      if (w_stb) begin
        case (r_state)
          S_HEAD: begin
            if (uart_data == HEAD) begin
              r_sum <= HEAD;
            end
          end
          S_TYPE: begin
            r_type <= uart_data;
            r_sum  <= r_sum + uart_data;
            r_idx  <= 3'd0;
          end
          S_DATA: begin
            r_buf[{r_idx, 3'b000} +: 8] <= uart_data;
            r_sum                       <= r_sum + uart_data;
            r_idx                       <= r_idx + 3'd1;
          end
          default: ;
        endcase
      end
    end
  end

  // group holding registers and strobes, updated on the checksum-byte edge
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_x     <= 16'h0;
      acc_y     <= 16'h0;
      acc_z     <= 16'h0;
      temp      <= 16'h0;
      gyro_x    <= 16'h0;
      gyro_y    <= 16'h0;
      gyro_z    <= 16'h0;
      roll      <= 16'h0;
      pitch     <= 16'h0;
      yaw       <= 16'h0;
      acc_vld   <= 1'b0;
      gyro_vld  <= 1'b0;
      angle_vld <= 1'b0;
      csum_err  <= 1'b0;
    end else begin
      acc_vld   <= w_commit && (r_type == T_ACC);
      gyro_vld  <= w_commit && (r_type == T_GYRO);
      angle_vld <= w_commit && (r_type == T_ANGLE);
      csum_err  <= w_bad;
      if (w_commit) begin
        case (r_type)
          T_ACC: begin
            acc_x <= r_buf[15:0];
            acc_y <= r_buf[31:16];
            acc_z <= r_buf[47:32];
            temp  <= r_buf[63:48];
          end
          T_GYRO: begin
            gyro_x <= r_buf[15:0];
            gyro_y <= r_buf[31:16];
            gyro_z <= r_buf[47:32];
          end
          T_ANGLE: begin
            roll  <= r_buf[15:0];
            pitch <= r_buf[31:16];
            yaw   <= r_buf[47:32];
          end
          default: ;
        endcase
      end
    end
  end

`ifdef JY61P_ERR_CNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_cnt <= 16'h0;
    end else if (err_clr) begin
      err_cnt <= 16'h0;
    end else if (w_bad && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_jy61p_frame_parser.sv
// tb/tb_jy61p_frame_parser.sv - directed self-checking bench for jy61p_frame_parser

module tb_jy61p_frame_parser;

  localparam int TMO = 1000;

  logic        clk;
  logic        rstn;
  logic        uart_done;
  logic [7:0]  uart_data;
  logic [15:0] acc_x, acc_y, acc_z, temp;
  logic [15:0] gyro_x, gyro_y, gyro_z;
  logic [15:0] roll, pitch, yaw;
  logic        acc_vld, gyro_vld, angle_vld, csum_err;
`ifdef JY61P_ERR_CNT_EN
  logic        err_clr;
  logic [15:0] err_cnt;
`endif

  int n_checks;
  int n_errs;

  int cnt_acc, cnt_gyro, cnt_angle, cnt_csum;
  int b_acc, b_gyro, b_angle, b_csum;

  logic [7:0] f_ang  [11];
  logic [7:0] f_acc  [11];
  logic [7:0] f_bad  [11];
  logic [7:0] f_gyr  [11];
  logic [7:0] f_unk  [11];

  jy61p_frame_parser #(.TIMEOUT_CYC(TMO)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .uart_done (uart_done),
    .uart_data (uart_data),
    .acc_x     (acc_x),
    .acc_y     (acc_y),
    .acc_z     (acc_z),
    .temp      (temp),
    .gyro_x    (gyro_x),
    .gyro_y    (gyro_y),
    .gyro_z    (gyro_z),
    .roll      (roll),
    .pitch     (pitch),
    .yaw       (yaw),
    .acc_vld   (acc_vld),
    .gyro_vld  (gyro_vld),
    .angle_vld (angle_vld),
`ifdef JY61P_ERR_CNT_EN
    .err_clr   (err_clr),
    .err_cnt   (err_cnt),
`endif
    .csum_err  (csum_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pulse monitors: a stretched pulse counts once per high cycle
  initial begin
    cnt_acc = 0; cnt_gyro = 0; cnt_angle = 0; cnt_csum = 0;
  end
  always @(negedge clk) begin
    if (acc_vld)   cnt_acc   = cnt_acc + 1;
    if (gyro_vld)  cnt_gyro  = cnt_gyro + 1;
    if (angle_vld) cnt_angle = cnt_angle + 1;
    if (csum_err)  cnt_csum  = cnt_csum + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
    @(posedge clk); #1;
    uart_data = b;
    uart_done = 1'b1;
    repeat (hold) @(posedge clk);
    #1 uart_done = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] f [11], input int hold, input int gap);
    for (int i = 0; i < 11; i++) send_byte(f[i], hold, gap);
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic mark;
    b_acc = cnt_acc; b_gyro = cnt_gyro; b_angle = cnt_angle; b_csum = cnt_csum;
  endtask

  initial begin
    n_checks = 0; n_errs = 0;
    f_ang = '{8'h55, 8'h53, 8'h10, 8'h00, 8'h20, 8'h00, 8'h30, 8'h00, 8'h00, 8'h00, 8'h08};
    f_acc = '{8'h55, 8'h51, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'h0A, 8'hC8};
    f_bad = '{8'h55, 8'h51, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'h0A, 8'hC9};
    f_gyr = '{8'h55, 8'h52, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'hAD};
    f_unk = '{8'h55, 8'h54, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA9};

    rstn = 1'b0; uart_done = 1'b0; uart_data = 8'h00;
`ifdef JY61P_ERR_CNT_EN
    err_clr = 1'b0;
`endif
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_val("rst_acc_x", {16'h0, acc_x}, 32'h0);
    check_val("rst_roll",  {16'h0, roll},  32'h0);
    check_val("rst_pulses", {28'h0, acc_vld, gyro_vld, angle_vld, csum_err}, 32'h0);
    #1 rstn = 1'b1;

    // angle frame
    mark();
    send_frame(f_ang, 1, 2);
    check_val("t1_roll",  {16'h0, roll},  32'h0010);
    check_val("t1_pitch", {16'h0, pitch}, 32'h0020);
    check_val("t1_yaw",   {16'h0, yaw},   32'h0030);
    check_val("t1_angle_vld", cnt_angle - b_angle, 1);
    check_val("t1_csum", cnt_csum - b_csum, 0);

    // accel frame, then same frame with bad checksum
    mark();
    send_frame(f_acc, 1, 2);
    check_val("t2_acc_x", {16'h0, acc_x}, 32'h0800);
    check_val("t2_acc_y", {16'h0, acc_y}, 32'h0);
    check_val("t2_acc_z", {16'h0, acc_z}, 32'h0);
    check_val("t2_temp",  {16'h0, temp},  32'h0A10);
    check_val("t2_acc_vld", cnt_acc - b_acc, 1);
    mark();
    send_frame(f_bad, 1, 2);
    check_val("t2b_csum", cnt_csum - b_csum, 1);
    check_val("t2b_acc_vld", cnt_acc - b_acc, 0);
    check_val("t2b_acc_x", {16'h0, acc_x}, 32'h0800);
    check_val("t2b_temp",  {16'h0, temp},  32'h0A10);

    // junk bytes before a gyro frame
    mark();
    send_byte(8'h12, 1, 2);
    send_byte(8'h34, 1, 2);
    send_frame(f_gyr, 1, 2);
    check_val("t3_gyro_x", {16'h0, gyro_x}, 32'h1);
    check_val("t3_gyro_y", {16'h0, gyro_y}, 32'h2);
    check_val("t3_gyro_z", {16'h0, gyro_z}, 32'h3);
    check_val("t3_gyro_vld", cnt_gyro - b_gyro, 1);
    check_val("t3_csum", cnt_csum - b_csum, 0);

    // unknown type with good checksum: silent
    mark();
    send_frame(f_unk, 1, 2);
    check_val("unk_pulses", (cnt_acc - b_acc) + (cnt_gyro - b_gyro) + (cnt_angle - b_angle) + (cnt_csum - b_csum), 0);
    check_val("unk_roll", {16'h0, roll}, 32'h0010);

    // partial frame dropped by inter-byte timeout
    mark();
    send_byte(8'h55, 1, 1);
    send_byte(8'h51, 1, 1);
    send_byte(8'h01, 1, 1);
    send_byte(8'h02, 1, 1);
    send_byte(8'h03, 1, 1);
    repeat (TMO + 10) @(posedge clk);
    send_frame(f_acc, 1, 2);
    check_val("t4_acc_vld", cnt_acc - b_acc, 1);
    check_val("t4_csum", cnt_csum - b_csum, 0);
    check_val("t4_acc_x", {16'h0, acc_x}, 32'h0800);

    // gaps well below the timeout keep the frame alive
    mark();
    send_frame(f_ang, 1, TMO / 2);
    check_val("gap_angle_vld", cnt_angle - b_angle, 1);
    check_val("gap_csum", cnt_csum - b_csum, 0);

    // long uart_done levels: one byte per level
    mark();
    send_frame(f_ang, 300, 3);
    check_val("t5_angle_vld", cnt_angle - b_angle, 1);
    check_val("t5_csum", cnt_csum - b_csum, 0);
    check_val("t5_yaw", {16'h0, yaw}, 32'h0030);

    // async reset mid-frame
    for (int i = 0; i < 5; i++) send_byte(f_acc[i], 1, 2);
    #3 rstn = 1'b0;
    @(negedge clk);
    check_val("t6_acc_x", {16'h0, acc_x}, 32'h0);
    check_val("t6_temp",  {16'h0, temp},  32'h0);
    check_val("t6_gyro_z", {16'h0, gyro_z}, 32'h0);
    check_val("t6_roll",  {16'h0, roll},  32'h0);
    @(posedge clk); #1 rstn = 1'b1;
    mark();
    send_frame(f_acc, 1, 2);
    check_val("t6_acc_vld", cnt_acc - b_acc, 1);
    check_val("t6_acc_x2", {16'h0, acc_x}, 32'h0800);
    check_val("t6_temp2",  {16'h0, temp},  32'h0A10);

`ifdef JY61P_ERR_CNT_EN
    check_val("ec_reset", {16'h0, err_cnt}, 32'h0);
    for (int i = 0; i < 3; i++) send_frame(f_bad, 1, 2);
    check_val("ec_three", {16'h0, err_cnt}, 32'h3);
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    check_val("ec_clr", {16'h0, err_cnt}, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
